skolem_bvneg_sle_sweeper: RTL and testbench

- Sequential verification stage placed directly downstream of the 4-bit bvsle/bvneg Skolem function block.
- Drives every t vector into the Skolem block and consumes its x output.
- Checks the inverse condition (-x) <=s t for each vector and accumulates pass/fail counts plus the first counterexample.
- Used as on-chip and in-sim self-check of generated Skolem netlists.

---
 rtl/skolem_bvneg_sle_sweeper_if.sv | 29 ++
 rtl/skolem_bvneg_sle_sweeper.sv | 112 +++++++++++
 tb/tb_skolem_bvneg_sle_sweeper.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/skolem_bvneg_sle_sweeper_if.sv
// Handshake/result bundle between the Skolem sweeper and its environment.
// The master side drives start/abort and returns x_in; the slave side is the sweeper.
interface skolem_bvneg_sle_sweeper_if #(
    parameter int W = 4
);
    logic         start;
    logic         abort;
    logic [W-1:0] t_out;
    logic [W-1:0] x_in;
    logic         busy;
    logic         done;
    logic [W:0]   pass_cnt;
    logic [W:0]   fail_cnt;
    logic         first_fail_valid;
    logic [W-1:0] first_fail_t;
    logic [W-1:0] first_fail_x;

    modport master (
        output start, abort, x_in,
        input  t_out, busy, done, pass_cnt, fail_cnt,
               first_fail_valid, first_fail_t, first_fail_x
    );

    modport slave (
        input  start, abort, x_in,
        output t_out, busy, done, pass_cnt, fail_cnt,
               first_fail_valid, first_fail_t, first_fail_x
    );
endinterface

// File: rtl/skolem_bvneg_sle_sweeper.sv
// Sweeps every t into a bvneg/bvsle Skolem block and checks (-x) <=s t per vector.
// Optional macro SKOLEM_SWEEP_STOP_ON_FAIL_EN ends the sweep on the first failing vector.
module skolem_bvneg_sle_sweeper #(
    parameter int W = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    skolem_bvneg_sle_sweeper_if.slave     bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t       r_state;
    logic [W-1:0] r_t;
    logic         r_busy;
    logic         r_done;
    logic [W:0]   r_pass_cnt;
    logic [W:0]   r_fail_cnt;
    logic         r_ff_valid;
    logic [W-1:0] r_ff_t;
    logic [W-1:0] r_ff_x;

    logic [W-1:0] w_neg_x;
    logic         w_pass;

    // Two's-complement negation; the most negative value maps onto itself and still compares correctly.
    always_comb begin
        w_neg_x = ~bus.x_in + {{(W-1){1'b0}}, 1'b1};
        w_pass  = ($signed(w_neg_x) <= $signed(r_t));
    end

    assign bus.t_out            = r_t;
    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
    assign bus.pass_cnt         = r_pass_cnt;
    assign bus.fail_cnt         = r_fail_cnt;
    assign bus.first_fail_valid = r_ff_valid;
    assign bus.first_fail_t     = r_ff_t;
    assign bus.first_fail_x     = r_ff_x;

    // Sweep FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_t        <= {W{1'b0}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass_cnt <= {(W+1){1'b0}};
            r_fail_cnt <= {(W+1){1'b0}};
            r_ff_valid <= 1'b0;
            r_ff_t     <= {W{1'b0}};
            r_ff_x     <= {W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_state    <= ST_RUN;
                        r_t        <= {W{1'b0}};
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass_cnt <= {(W+1){1'b0}};
                        r_fail_cnt <= {(W+1){1'b0}};
                        r_ff_valid <= 1'b0;
                        r_ff_t     <= {W{1'b0}};
                        r_ff_x     <= {W{1'b0}};
                    end else begin
                        r_state <= r_state;
                    end
                end
                ST_RUN: begin
                    if (w_pass) begin
                        r_pass_cnt <= r_pass_cnt + {{W{1'b0}}, 1'b1};
                    end else begin
                        r_fail_cnt <= r_fail_cnt + {{W{1'b0}}, 1'b1};
                        if (!r_ff_valid) begin
                            r_ff_valid <= 1'b1;
                            r_ff_t     <= r_t;
                            r_ff_x     <= bus.x_in;
                        end else begin
                            r_ff_valid <= r_ff_valid;
                        end
                    end
                    // Abort outranks both normal completion and stop-on-fail.
                    if (bus.abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
`ifdef SKOLEM_SWEEP_STOP_ON_FAIL_EN
                    end else if (!w_pass) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`endif
                    end else if (r_t == {W{1'b1}}) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_t <= r_t + {{(W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_skolem_bvneg_sle_sweeper.sv
// Self-checking bench: a lookup-table Skolem model feeds x_in, an arithmetic reference predicts the results.
module tb_skolem_bvneg_sle_sweeper;
    localparam int W = 4;
    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] lut [N];
    int         n_assert = 0;
    int         n_fail   = 0;

    skolem_bvneg_sle_sweeper_if #(.W(W)) bif ();

    assign bif.x_in = lut[bif.t_out];

    skolem_bvneg_sle_sweeper #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sgn(input int v);
        return (v >= N/2) ? v - N : v;
    endfunction

    // Reference: walk all t in order, apply the signed-compare rule with integer arithmetic.
    function automatic void model(output int p, output int f, output int ffv, output int fft,
                                  output int ffx, output int cyc, output int tend);
        int x, neg;
        p = 0; f = 0; ffv = 0; fft = 0; ffx = 0; cyc = 0; tend = 0;
        for (int t = 0; t < N; t++) begin
            x    = int'(lut[t]);
            neg  = (N - x) % N;
            cyc++;
            tend = t;
            if (sgn(neg) <= sgn(t)) begin
                p++;
            end else begin
                f++;
                if (ffv == 0) begin
                    ffv = 1; fft = t; ffx = x;
                end
`ifdef SKOLEM_SWEEP_STOP_ON_FAIL_EN
                break;
`endif
            end
        end
    endfunction

    task automatic pulse_start();
        @(negedge clk); bif.start = 1'b1;
        @(negedge clk); bif.start = 1'b0;
    endtask

    task automatic wait_t(input int v);
        int k = 0;
        while (bif.t_out !== v[3:0] && k < 40) begin
            @(negedge clk); k++;
        end
        chk("wait_t_reached", bif.t_out, v);
    endtask

    task automatic run_sweep(input string tag);
        int p, f, ffv, fft, ffx, cyc, tend, n;
        model(p, f, ffv, fft, ffx, cyc, tend);
        pulse_start();
        n = 0;
        while (bif.busy === 1'b1 && n < 40) begin
            chk({tag, "_t_seq"}, bif.t_out, n);
            n++;
            @(negedge clk);
        end
        chk({tag, "_cycles"}, n, cyc);
        chk({tag, "_done"}, bif.done, 1);
        chk({tag, "_busy"}, bif.busy, 0);
        chk({tag, "_pass"}, bif.pass_cnt, p);
        chk({tag, "_fail"}, bif.fail_cnt, f);
        chk({tag, "_ffv"}, bif.first_fail_valid, ffv);
        chk({tag, "_fft"}, bif.first_fail_t, fft);
        chk({tag, "_ffx"}, bif.first_fail_x, ffx);
        chk({tag, "_tend"}, bif.t_out, tend);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_t"}, bif.t_out, 0);
        chk({tag, "_busy"}, bif.busy, 0);
        chk({tag, "_done"}, bif.done, 0);
        chk({tag, "_pass"}, bif.pass_cnt, 0);
        chk({tag, "_fail"}, bif.fail_cnt, 0);
        chk({tag, "_ffv"}, bif.first_fail_valid, 0);
        chk({tag, "_fft"}, bif.first_fail_t, 0);
        chk({tag, "_ffx"}, bif.first_fail_x, 0);
    endtask

    initial begin
        bif.start = 1'b0;
        bif.abort = 1'b0;
        for (int i = 0; i < N; i++) lut[i] = 4'd8;
        #12;
        chk_reset("rst_held");
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk_reset("after_rst");

        // Correct Skolem model x = 8.
        run_sweep("x8");
        @(negedge clk); @(negedge clk);
        chk("done_hold", bif.done, 1);

        // Faulty x = 0.
        for (int i = 0; i < N; i++) lut[i] = 4'd0;
        run_sweep("x0");

        // Faulty x = t.
        for (int i = 0; i < N; i++) lut[i] = 4'(i);
        run_sweep("xt");

        // Random Skolem tables.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) lut[i] = 4'($urandom_range(15, 0));
            run_sweep("rand");
        end

        // Abort on t = 5 with the correct model.
        for (int i = 0; i < N; i++) lut[i] = 4'd8;
        pulse_start();
        wait_t(5);
        bif.abort = 1'b1;
        @(negedge clk); bif.abort = 1'b0;
        chk("abort_busy", bif.busy, 0);
        chk("abort_done", bif.done, 0);
        chk("abort_pass", bif.pass_cnt, 6);
        chk("abort_fail", bif.fail_cnt, 0);
        @(negedge clk);
        chk("abort_idle_busy", bif.busy, 0);
        run_sweep("post_abort");

        // Asynchronous reset mid-sweep.
        pulse_start();
        wait_t(10);
        #2 rst = 1'b1;
        #1 chk_reset("async_rst");
        @(negedge clk); rst = 1'b0;
        run_sweep("post_rst");

        // start ignored in RUN; start+abort together in RUN aborts.
        pulse_start();
        wait_t(3);
        bif.start = 1'b1;
        @(negedge clk); bif.start = 1'b0;
        chk("start_in_run_t", bif.t_out, 4);
        chk("start_in_run_busy", bif.busy, 1);
        wait_t(6);
        bif.start = 1'b1; bif.abort = 1'b1;
        @(negedge clk); bif.start = 1'b0; bif.abort = 1'b0;
        chk("start_abort_busy", bif.busy, 0);
        chk("start_abort_done", bif.done, 0);
        chk("start_abort_pass", bif.pass_cnt, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
